load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator for the word-addressed 32-bit data memory port (A/WD/WE/RD, async read, sync word write).
//  Accepts RV32I load/store requests from the core and performs sub-word lane extraction and sign/zero extension.
//  Sub-word stores are done as read-modify-write, because memory writes whole words only.
//  Sits between the execute stage and data memory.
// PARAMETERS
//  ADDR_W   32  byte-address width on both core and memory sides
//  MEM_WORDS 1024 memory depth in words; request address bits above log2(MEM_WORDS)+2 are ignored
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous active-low reset
//  req_valid  in   1   core request valid
//  req_ready  out  1   unit can accept; high only in IDLE
//  req_store  in   1   1=store, 0=load
//  req_funct3 in   3   RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data; low bits are used for B/H
//  resp_valid out  1   response valid (loads and stores)
//  resp_ready in   1   core accepts response
//  resp_rdata out  32  extended load data; 0 for stores
//  resp_fault out  1   misaligned/illegal funct3 (see CONFIGURATION)
//  mem_a      out  32  memory byte address, always word aligned ([1:0]=00)
//  mem_wd     out  32  memory write data
//  mem_we     out  1   memory write enable, one cycle per store
//  mem_rd     in   32  memory read data, combinational from mem_a
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; mem_we=0; mem_a=0; mem_wd=0.
//  Accept: req_valid&&req_ready at a rising edge. Address, data, funct3 and store are registered at that edge.
//  States:
//   IDLE: ready=1. Transitions on accept: load->LOAD, store word->WRITE, store B/H->READ, fault->RESP.
//   LOAD: mem_a=word addr. At the edge, capture mem_rd, extract lane, extend -> RESP.
//   READ: mem_a=word addr. At the edge, capture mem_rd and merge the byte/half into the addressed lane -> WRITE.
//   WRITE: mem_a=word addr, mem_wd=merged (or full word), mem_we=1 for exactly this cycle -> RESP.
//   RESP: resp_valid=1, outputs stable. Leaves to IDLE when resp_ready=1.
//  Response timing (resp_ready tied high, accept at edge 0):
//   load: resp_valid in cycle 2.
//   SW: mem_we in cycle 1, resp in cycle 2.
//   SB/SH: mem_we in cycle 2, resp in cycle 3.
//  Back-to-back: the next accept occurs one cycle after the RESP handshake. There is no request/response overlap.
//  mem_we is never asserted outside WRITE, and never during reset.
//  Lane select: byte lane = addr[1:0]; half lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
//  Illegal funct3 is faulted: load with 011/110/111, store with funct3 > 010.
//   A faulted request goes straight to RESP with resp_fault=1 and resp_rdata=0, and causes no memory access.
//  Reset mid-operation: return to IDLE immediately. Any pending write is abandoned (mem_we drops asynchronously).
//  Address wrap: the word index is addr[log2(MEM_WORDS)+1:2]; upper bits are dropped silently.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   Any H with addr[0]!=0, or W with addr[1:0]!=0, is faulted.
//   It is treated like an illegal funct3 (RESP, fault=1, no memory access).
//  MISALIGN_TRAP_EN undefined:
//   Low address bits below the access size are forced to zero (H uses addr[1]; W ignores [1:0]).
//   resp_fault then reflects illegal funct3 only.
// STRUCTURE
//  Package lsu_pkg holds:
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
//   - state encoding IDLE/LOAD/READ/WRITE/RESP (3-bit)
//   - the word-index width function
//  One sub-module, lsu_lane_align (combinational), provides load extract+extend and store merge.
//  The FSM and request/response registers live in load_store_unit.
// TESTING
//  Preload mem[1]=0x80FF_7F01. LB @0x5 -> 0x0000_007F; LB @0x7 -> 0xFFFF_FF80; LBU @0x6 -> 0x0000_00FF.
//  LH @0x6 -> 0xFFFF_80FF; LHU @0x6 -> 0x0000_80FF; LW @0x4 -> 0x80FF_7F01, resp in cycle 2.
//  SB 0xAB @0x9, with mem[2]=0x1122_3344 -> mem[2]=0x1122_AB44. mem_we high exactly 1 cycle, in cycle 2.
//  SH 0xBEEF @0xA -> mem[2]=0xBEEF_xxxx with the low half preserved. SW 0xDEAD_BEEF @0xC -> mem[3] written in cycle 1.
//  resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0. Then a handshake, and the next request accepts one cycle later.
//  LW @0x6: with MISALIGN_TRAP_EN, fault=1 with no mem access; without it, reads mem[1].
//  Also: load funct3=011 -> fault. rst pulse low while in WRITE -> mem_we=0 at once, IDLE, memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM
// state encoding and the word-index width helper.
// Optional feature macro used by the unit: MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    // Number of address bits that select a word inside the memory.
    function automatic int word_idx_w(input int mem_words);
        return (mem_words > 1) ? $clog2(mem_words) : 1;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges byte/half store data into a previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [3:0]  lane_we;
    logic [31:0] wdata_rep;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Halfword accesses only look at addr[1]; addr[0] is treated as zero.
    assign sel_byte = lane[byte_off];
    assign sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

    // Load path: pick the addressed lane and sign/zero extend it.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'b0, sel_byte};
            F3_HU:   load_data = {16'b0, sel_half};
            default: load_data = '0;
        endcase
    end

    // Store path: decide which byte lanes take new data and replicate the
    // store data so every candidate lane already holds the right bits.
    always_comb begin
        lane_we   = 4'b0000;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                lane_we[byte_off] = 1'b1;
                wdata_rep         = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_we   = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                lane_we   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign store_word[8*gi +: 8] = lane_we[gi] ? wdata_rep[8*gi +: 8] : lane[gi];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-addressed memory port with async
// read and synchronous word write. Byte/half stores use read-modify-write.
// Build option: define MISALIGN_TRAP_EN to fault misaligned H/W accesses;
// otherwise the low address bits below the access size are ignored.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    localparam int IDX_W = word_idx_w(MEM_WORDS);

    lsu_state_e        state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [31:0]       mem_wd_q;
    logic              mem_we_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_fault_q;

    logic [ADDR_W-1:0] mem_a_d;
    logic              req_fault;
    logic [31:0]       load_data;
    logic [31:0]       store_word;
    logic              unused_addr_hi;

    // Word address: upper request bits beyond the memory depth wrap away.
    assign mem_a_d        = {{(ADDR_W-IDX_W-2){1'b0}}, req_addr[IDX_W+1:2], 2'b00};
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    // Classify the incoming request as faulting (illegal size, or misaligned when trapping).
    always_comb begin
        req_fault = 1'b0;
        if (req_store) begin
            req_fault = (req_funct3 > F3_W);
        end else begin
            req_fault = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
`ifdef MISALIGN_TRAP_EN
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            req_fault = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
`endif
    end

    lsu_lane_align u_lane_align (
        .funct3     (funct3_q),
        .byte_off   (addr_lo_q),
        .rdata      (mem_rd),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Request/response FSM; all memory and response outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            funct3_q     <= F3_B;
            addr_lo_q    <= 2'b00;
            wdata_q      <= '0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            mem_we_q     <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q     <= req_funct3;
                        addr_lo_q    <= req_addr[1:0];
                        wdata_q      <= req_wdata;
                        mem_a_q      <= mem_a_d;
                        resp_rdata_q <= '0;
                        resp_fault_q <= req_fault;
                        if (req_fault) begin
                            state_q <= RESP;
                        end else if (!req_store) begin
                            state_q <= LOAD;
                        end else if (req_funct3 == F3_W) begin
                            mem_wd_q <= req_wdata;
                            mem_we_q <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata_q <= load_data;
                    state_q      <= RESP;
                end
                READ: begin
                    mem_wd_q <= store_word;
                    mem_we_q <= 1'b1;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    mem_we_q <= 1'b0;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (resp_ready)
                        state_q <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table from the
// documented examples, hand-written stall/reset sequences, and a random
// phase checked against an arithmetic reference model of loads/stores.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] tb_mem  [1024];
    logic [31:0] ref_mem [1024];
    logic        load_mem;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: async read, synchronous word write.
    assign mem_rd = tb_mem[mem_a[11:2]];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            tb_mem[mem_a[11:2]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit [31:0] ref_load(bit [31:0] w, bit [2:0] f3, bit [31:0] a);
        bit [31:0] b;
        bit [31:0] h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit [31:0] ref_store(bit [31:0] w, bit [2:0] f3, bit [31:0] a, bit [31:0] d);
        int sh;
        if (f3 == 3'd0) begin
            sh = 8 * a[1:0];
            return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh = 16 * a[1];
            return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    function automatic bit ref_fault(bit st, bit [2:0] f3, bit [31:0] a);
        bit bad;
        if (st) bad = (f3 > 3'd2);
        else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef MISALIGN_TRAP_EN
        if (!bad) begin
            if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1'b1;
            if (f3 == 3'd2 && a[1:0] != 2'b00)      bad = 1'b1;
        end
`endif
        return bad;
    endfunction

    // One request from accept to handshake. Cycle n = n-th cycle after the accept edge.
    task automatic transact(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                            input bit [31:0] wd, input int hold,
                            output bit [31:0] rd, output bit flt, output int rcyc,
                            output int we_n, output int we_cyc, output bit [31:0] we_addr);
        @(negedge clk);
        chk("req_ready before accept", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        rd = 0; flt = 0; rcyc = 0; we_n = 0; we_cyc = 0; we_addr = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (mem_we) begin
                we_n++;
                we_cyc  = n;
                we_addr = mem_a;
            end
            if (resp_valid) begin
                rcyc = n;
                rd   = resp_rdata;
                flt  = resp_fault;
                break;
            end
        end
        if (rcyc == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp timeout: no resp_valid within 20 cycles");
        end else if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("stall resp_valid", {31'b0, resp_valid}, 32'd1);
                chk("stall resp_rdata", resp_rdata, rd);
                chk("stall req_ready", {31'b0, req_ready}, 32'd0);
                chk("stall mem_we", {31'b0, mem_we}, 32'd0);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] exp_rd;
        bit        exp_flt;
        int        exp_rcyc;
        int        exp_we_cyc;
        int        chk_idx;
        bit [31:0] exp_word;
    } vec_t;

    function automatic vec_t mk(bit st, bit [2:0] f3, bit [31:0] addr, bit [31:0] wd,
                                bit [31:0] exp_rd, bit exp_flt, int exp_rcyc,
                                int exp_we_cyc, int chk_idx, bit [31:0] exp_word);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.exp_rd = exp_rd;
        v.exp_flt = exp_flt; v.exp_rcyc = exp_rcyc; v.exp_we_cyc = exp_we_cyc;
        v.chk_idx = chk_idx; v.exp_word = exp_word;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] rd, we_addr, exp_rd, idx, ad, wd, saved;
        bit        flt, exp_flt, st;
        bit [2:0]  f3;
        int        rcyc, we_n, we_cyc, hold, exp_rcyc, exp_we_cyc;

        vecs[0]  = mk(0, 3'd0, 32'h5,  0, 32'h0000_007F, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[1]  = mk(0, 3'd0, 32'h7,  0, 32'hFFFF_FF80, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[2]  = mk(0, 3'd4, 32'h6,  0, 32'h0000_00FF, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[3]  = mk(0, 3'd1, 32'h6,  0, 32'hFFFF_80FF, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[4]  = mk(0, 3'd5, 32'h6,  0, 32'h0000_80FF, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[5]  = mk(0, 3'd2, 32'h4,  0, 32'h80FF_7F01, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[6]  = mk(1, 3'd0, 32'h9,  32'h0000_00AB, 0, 0, 3, 2, 2, 32'h1122_AB44);
        vecs[7]  = mk(1, 3'd1, 32'hA,  32'h0000_BEEF, 0, 0, 3, 2, 2, 32'hBEEF_AB44);
        vecs[8]  = mk(1, 3'd2, 32'hC,  32'hDEAD_BEEF, 0, 0, 2, 1, 3, 32'hDEAD_BEEF);
        vecs[9]  = mk(0, 3'd0, 32'hB,  0, 32'hFFFF_FFBE, 0, 2, 0, 2, 32'hBEEF_AB44);
        vecs[10] = mk(0, 3'd3, 32'h4,  0, 32'h0, 1, 1, 0, 1, 32'h80FF_7F01);
        vecs[11] = mk(1, 3'd4, 32'h8,  32'h1234_5678, 0, 1, 1, 0, 2, 32'hBEEF_AB44);
`ifdef MISALIGN_TRAP_EN
        vecs[12] = mk(0, 3'd2, 32'h6,  0, 32'h0, 1, 1, 0, 1, 32'h80FF_7F01);
`else
        vecs[12] = mk(0, 3'd2, 32'h6,  0, 32'h80FF_7F01, 0, 2, 0, 1, 32'h80FF_7F01);
`endif
        vecs[13] = mk(0, 3'd4, 32'h1007, 0, 32'h0000_0080, 0, 2, 0, 1, 32'h80FF_7F01);
        vecs[14] = mk(1, 3'd0, 32'hC,  32'hFFFF_FF5A, 0, 0, 3, 2, 3, 32'hDEAD_BE5A);

        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h80FF_7F01;
        ref_mem[2] = 32'h1122_3344;
        ref_mem[3] = 32'h0000_0000;

        rst = 1'b0; load_mem = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 0; req_wdata = 0; resp_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("reset mem_we", {31'b0, mem_we}, 32'd0);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset mem_wd", mem_wd, 32'd0);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            transact(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, 0,
                     rd, flt, rcyc, we_n, we_cyc, we_addr);
            $display("vec %0d st=%0d f3=%0d addr=%h rdata=%h fault=%0d resp_cyc=%0d we_cyc=%0d",
                     i, vecs[i].st, vecs[i].f3, vecs[i].addr, rd, flt, rcyc, we_cyc);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d fault", i), {31'b0, flt}, {31'b0, vecs[i].exp_flt});
            chk($sformatf("vec%0d resp cycle", i), rcyc, vecs[i].exp_rcyc);
            chk($sformatf("vec%0d we count", i), we_n, (vecs[i].exp_we_cyc != 0) ? 1 : 0);
            chk($sformatf("vec%0d we cycle", i), we_cyc, vecs[i].exp_we_cyc);
            chk($sformatf("vec%0d mem word", i), tb_mem[vecs[i].chk_idx], vecs[i].exp_word);
            if (vecs[i].st && !vecs[i].exp_flt) begin
                idx = {22'b0, vecs[i].addr[11:2]};
                ref_mem[idx] = ref_store(ref_mem[idx], vecs[i].f3, vecs[i].addr, vecs[i].wd);
            end
        end

        // Response stall, then an immediate back-to-back request.
        transact(0, 3'd2, 32'h4, 0, 5, rd, flt, rcyc, we_n, we_cyc, we_addr);
        $display("stall LW rdata=%h resp_cyc=%0d", rd, rcyc);
        chk("stall LW rdata", rd, 32'h80FF_7F01);
        transact(0, 3'd0, 32'h5, 0, 0, rd, flt, rcyc, we_n, we_cyc, we_addr);
        $display("b2b LB rdata=%h resp_cyc=%0d", rd, rcyc);
        chk("b2b LB rdata", rd, 32'h0000_007F);
        chk("b2b LB resp cycle", rcyc, 2);

        // Reset pulse while a word store is in WRITE.
        saved = ref_mem[4];
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h10; req_wdata = ~saved;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre-reset mem_we", {31'b0, mem_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("reset-in-write mem_we", {31'b0, mem_we}, 32'd0);
        chk("reset-in-write req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset-in-write resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        $display("reset-in-write mem[4]=%h", tb_mem[4]);
        chk("reset-in-write mem unchanged", tb_mem[4], saved);

        // Random phase against the reference model.
        for (int t = 0; t < 300; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            ad   = $urandom;
            wd   = $urandom;
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            idx  = {22'b0, ad[11:2]};

            exp_flt    = ref_fault(st, f3, ad);
            exp_rd     = 0;
            exp_we_cyc = 0;
            if (exp_flt) begin
                exp_rcyc = 1;
            end else if (!st) begin
                exp_rd   = ref_load(ref_mem[idx], f3, ad);
                exp_rcyc = 2;
            end else if (f3 == 3'd2) begin
                exp_rcyc   = 2;
                exp_we_cyc = 1;
            end else begin
                exp_rcyc   = 3;
                exp_we_cyc = 2;
            end
            if (st && !exp_flt) ref_mem[idx] = ref_store(ref_mem[idx], f3, ad, wd);

            transact(st, f3, ad, wd, hold, rd, flt, rcyc, we_n, we_cyc, we_addr);
            $display("rnd %0d st=%0d f3=%0d addr=%h wd=%h rdata=%h fault=%0d resp_cyc=%0d",
                     t, st, f3, ad, wd, rd, flt, rcyc);
            chk("rnd rdata", rd, exp_rd);
            chk("rnd fault", {31'b0, flt}, {31'b0, exp_flt});
            chk("rnd resp cycle", rcyc, exp_rcyc);
            chk("rnd we count", we_n, (exp_we_cyc != 0) ? 1 : 0);
            chk("rnd we cycle", we_cyc, exp_we_cyc);
            if (exp_we_cyc != 0) chk("rnd we addr", we_addr, idx << 2);
            chk("rnd mem word", tb_mem[idx], ref_mem[idx]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
